// File: rtl/stream_demux4.sv
// rtl/stream_demux4.sv - registered 1:4 stream demux with per-packet select lock; optional DEMUX_COUNT_EN per-channel drain counters
module stream_demux4 #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          E,
   input  logic [1:0]    S,
   input  logic [DW-1:0] I_data,
   input  logic          I_valid,
   input  logic          I_last,
   output logic          I_ready,
   output logic [DW-1:0] Y_data,
   output logic          Y_last,
   output logic [3:0]    Y_valid,
   input  logic [3:0]    Y_ready
`ifdef DEMUX_COUNT_EN
   ,
   output logic [63:0]   Y_count
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic          full_q, full_d;
   logic [DW-1:0] data_q, data_d;
   logic          last_q, last_d;
   logic [1:0]    ch_q, ch_d;

   logic          drain;
   logic          accept;
   logic [1:0]    ch_in;

   assign drain   = full_q & Y_ready[ch_q];
   assign I_ready = E & ~rst & (~full_q | drain);
   assign accept  = I_valid & I_ready;
   assign ch_in   = (state_q == IDLE) ? S : sel_q;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      full_d  = full_q;
      data_d  = data_q;
      last_d  = last_q;
      ch_d    = ch_q;

      if (drain) begin
         full_d = 1'b0;
      end
      // A new beat overwrites the entry only once the old one is gone or leaving.
      if (accept) begin
         full_d = 1'b1;
         data_d = I_data;
         last_d = I_last;
         ch_d   = ch_in;
      end

      case (state_q)
         IDLE: begin
            if (accept && !I_last) begin
               sel_d   = S;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (accept && I_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 2'b00;
         full_q  <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         ch_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         full_q  <= full_d;
         data_q  <= data_d;
         last_q  <= last_d;
         ch_q    <= ch_d;
      end
   end

   always_comb begin
      Y_valid = 4'b0000;
      if (full_q) begin
         Y_valid[ch_q] = 1'b1;
      end
      Y_data = full_q ? data_q : '0;
      Y_last = full_q & last_q;
   end

`ifdef DEMUX_COUNT_EN
   logic [3:0][15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (drain) begin
         count_d[ch_q] = count_q[ch_q] + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign Y_count = count_q;
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// tb/tb_stream_demux4.sv - table-driven and directed-sequence bench for stream_demux4 (DEMUX_COUNT_EN aware)
module tb_stream_demux4;

   logic       clk;
   logic       rst;
   logic       E;
   logic [1:0] S;
   logic [7:0] I_data;
   logic       I_valid;
   logic       I_last;
   logic       I_ready;
   logic [7:0] Y_data;
   logic       Y_last;
   logic [3:0] Y_valid;
   logic [3:0] Y_ready;
`ifdef DEMUX_COUNT_EN
   logic [63:0] Y_count;
`endif

   int n_cmp;
   int n_fail;

   stream_demux4 #(.DW(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .E       (E),
      .S       (S),
      .I_data  (I_data),
      .I_valid (I_valid),
      .I_last  (I_last),
      .I_ready (I_ready),
      .Y_data  (Y_data),
      .Y_last  (Y_last),
      .Y_valid (Y_valid),
      .Y_ready (Y_ready)
`ifdef DEMUX_COUNT_EN
      ,
      .Y_count (Y_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       e;
      logic [1:0] s;
      logic [7:0] d;
      logic       v;
      logic       l;
      logic [3:0] yr;
      logic       x_ir;
      logic [3:0] x_yv;
      logic [7:0] x_yd;
      logic       x_yl;
   } vec_t;

   vec_t tv[16];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic [1:0] s, input logic [7:0] d,
                        input logic v, input logic l, input logic [3:0] yr);
      rst = r; E = e; S = s; I_data = d; I_valid = v; I_last = l; Y_ready = yr;
      #1;
   endtask

   task automatic chk_all(input string nm, input logic ir, input logic [3:0] yv,
                          input logic [7:0] yd, input logic yl);
      chk({nm, ".I_ready"}, {15'd0, I_ready}, {15'd0, ir});
      chk({nm, ".Y_valid"}, {12'd0, Y_valid}, {12'd0, yv});
      chk({nm, ".Y_data"},  {8'd0, Y_data},   {8'd0, yd});
      chk({nm, ".Y_last"},  {15'd0, Y_last},  {15'd0, yl});
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;

      //        rst   e     s      d      v     l     yr       ir    yv       yd     yl
      tv[0]  = '{1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 4'hF,    1'b0, 4'b0000, 8'h00, 1'b0};
      tv[1]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 1'b1, 1'b1, 4'hF,    1'b1, 4'b0000, 8'h00, 1'b0};
      tv[2]  = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 4'hF,    1'b1, 4'b0100, 8'hA5, 1'b1};
      tv[3]  = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 4'hF,    1'b1, 4'b0000, 8'h00, 1'b0};
      tv[4]  = '{1'b0, 1'b1, 2'd1, 8'h11, 1'b1, 1'b0, 4'hF,    1'b1, 4'b0000, 8'h00, 1'b0};
      tv[5]  = '{1'b0, 1'b1, 2'd3, 8'h22, 1'b1, 1'b0, 4'hF,    1'b1, 4'b0010, 8'h11, 1'b0};
      tv[6]  = '{1'b0, 1'b1, 2'd3, 8'h33, 1'b1, 1'b1, 4'hF,    1'b1, 4'b0010, 8'h22, 1'b0};
      tv[7]  = '{1'b0, 1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 4'hF,    1'b1, 4'b0010, 8'h33, 1'b1};
      tv[8]  = '{1'b0, 1'b1, 2'd0, 8'h5C, 1'b1, 1'b1, 4'h0,    1'b1, 4'b0000, 8'h00, 1'b0};
      tv[9]  = '{1'b0, 1'b1, 2'd1, 8'h77, 1'b1, 1'b0, 4'h0,    1'b0, 4'b0001, 8'h5C, 1'b1};
      tv[10] = '{1'b0, 1'b1, 2'd3, 8'h78, 1'b1, 1'b0, 4'b1110, 1'b0, 4'b0001, 8'h5C, 1'b1};
      tv[11] = '{1'b0, 1'b0, 2'd2, 8'h79, 1'b1, 1'b1, 4'h0,    1'b0, 4'b0001, 8'h5C, 1'b1};
      tv[12] = '{1'b0, 1'b1, 2'd2, 8'h7A, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0001, 8'h5C, 1'b1};
      tv[13] = '{1'b0, 1'b1, 2'd1, 8'h7B, 1'b0, 1'b0, 4'h0,    1'b0, 4'b0001, 8'h5C, 1'b1};
      tv[14] = '{1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'h5C, 1'b1};
      tv[15] = '{1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 4'hF,    1'b1, 4'b0000, 8'h00, 1'b0};

      drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0);
      step();
      step();

      for (int i = 0; i < 16; i++) begin
         drive(tv[i].rst, tv[i].e, tv[i].s, tv[i].d, tv[i].v, tv[i].l, tv[i].yr);
         chk_all($sformatf("vec%0d", i), tv[i].x_ir, tv[i].x_yv, tv[i].x_yd, tv[i].x_yl);
         step();
      end

      // enable dropped mid-packet: remainder must stay on channel 3
      drive(1'b0, 1'b1, 2'd3, 8'hC1, 1'b1, 1'b0, 4'hF);
      chk_all("en_a", 1'b1, 4'b0000, 8'h00, 1'b0);
      step();
      drive(1'b0, 1'b0, 2'd0, 8'hC2, 1'b1, 1'b0, 4'hF);
      chk_all("en_b", 1'b0, 4'b1000, 8'hC1, 1'b0);
      step();
      drive(1'b0, 1'b0, 2'd0, 8'hC2, 1'b1, 1'b0, 4'hF);
      chk_all("en_c", 1'b0, 4'b0000, 8'h00, 1'b0);
      step();
      drive(1'b0, 1'b1, 2'd0, 8'hC2, 1'b1, 1'b0, 4'hF);
      chk_all("en_d", 1'b1, 4'b0000, 8'h00, 1'b0);
      step();
      drive(1'b0, 1'b1, 2'd0, 8'hC3, 1'b1, 1'b1, 4'hF);
      chk_all("en_e", 1'b1, 4'b1000, 8'hC2, 1'b0);
      step();
      drive(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 4'hF);
      chk_all("en_f", 1'b1, 4'b1000, 8'hC3, 1'b1);
      step();
      chk_all("en_g", 1'b1, 4'b0000, 8'h00, 1'b0);

      // reset while BUSY with the entry full
      drive(1'b0, 1'b1, 2'd1, 8'hD1, 1'b1, 1'b0, 4'h0);
      chk_all("rs_a", 1'b1, 4'b0000, 8'h00, 1'b0);
      step();
      drive(1'b1, 1'b1, 2'd1, 8'h00, 1'b0, 1'b0, 4'h0);
      chk_all("rs_b", 1'b0, 4'b0010, 8'hD1, 1'b0);
      step();
      drive(1'b0, 1'b1, 2'd0, 8'hD2, 1'b1, 1'b1, 4'hF);
      chk_all("rs_c", 1'b1, 4'b0000, 8'h00, 1'b0);
      step();
      drive(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 4'hF);
      chk_all("rs_d", 1'b1, 4'b0001, 8'hD2, 1'b1);
      step();

`ifdef DEMUX_COUNT_EN
      drive(1'b1, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 4'hF);
      step();
      chk("cnt_reset", Y_count[47:32], 16'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 2'd2, 8'(i), 1'b1, 1'b1, 4'hF);
         step();
      end
      drive(1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 4'hF);
      step();
      chk("cnt_ch2", Y_count[47:32], 16'd4);
      chk("cnt_ch0", Y_count[15:0], 16'd0);
      for (int i = 0; i < 65531; i++) begin
         drive(1'b0, 1'b1, 2'd2, 8'h00, 1'b1, 1'b1, 4'hF);
         step();
      end
      drive(1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 4'hF);
      step();
      chk("cnt_max", Y_count[47:32], 16'hFFFF);
      drive(1'b0, 1'b1, 2'd2, 8'h00, 1'b1, 1'b1, 4'hF);
      step();
      drive(1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 4'hF);
      step();
      chk("cnt_wrap", Y_count[47:32], 16'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_demux4.md
Name: stream_demux4

Overview:
- 1-to-4 registered stream demultiplexer with enable. It is the inverse of the team's 4:1 enable multiplexer.
- A single valid/ready input stream is routed to one of four output channels, chosen by a 2-bit select S.
- The select is locked for the duration of a packet, which is delimited by I_last.
- Sits between a single producer and four consumer lanes in the combinational/sequential lab datapath.

Parameters:
- DW, 8, data width of I_data and Y_data.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- E  input  1  enable; when low, no new beat is accepted.
- S  input  2  destination select; sampled only on the first beat of a packet.
- I_data  input  DW  input beat data.
- I_valid  input  1  input beat valid.
- I_last  input  1  marks the final beat of a packet.
- I_ready  output  1  block can accept the beat this cycle.
- Y_data  output  DW  output data, shared by all four channels.
- Y_last  output  1  last flag travelling with Y_data.
- Y_valid  output  4  one-hot per-channel valid; bit n means channel n holds a beat.
- Y_ready  input  4  per-channel ready from the consumers.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - Y_valid = 4'b0000, Y_data = 0, Y_last = 0.
  - Internal state = IDLE, sel_q = 2'b00.
  - I_ready is combinational and therefore 0 during reset.
- Holding register: one output entry (data, last, channel).
- Drain: the held beat is consumed when Y_valid[ch] & Y_ready[ch].
- Ready: I_ready = E & ~rst & (entry empty | entry drains this cycle).
- Acceptance: a beat is accepted when I_valid & I_ready.
- Latency: an accepted beat appears on Y_* the next cycle. Back-to-back drain and accept in the same cycle gives 1 beat/cycle throughput.
- Destination: the accepted beat goes to channel ch = (state == IDLE) ? S : sel_q.
  - Y_valid = one-hot(ch) while the entry is full, else 0.
  - Y_data and Y_last are forced to 0 when the entry is empty.
- State machine:
  - IDLE: an accepted beat with I_last = 0 latches sel_q <= S and moves to BUSY. An accepted beat with I_last = 1 is a single-beat packet and stays in IDLE.
  - BUSY: S is ignored. An accepted beat with I_last = 1 returns to IDLE. Otherwise the block stays in BUSY.
- Enable low:
  - I_ready = 0.
  - The held beat still drains.
  - State and sel_q are retained, so a packet resumes on the same channel once E returns high.
- Hold rule: the held beat stays stable, with unchanged data, last and channel, until drained, whatever S, E or I_* do.
- Unselected channels: Y_ready on a channel without valid has no effect.
- Reset mid-packet:
  - The held beat is discarded and Y_valid clears next cycle.
  - State goes to IDLE.
  - The remainder of the packet is treated as a new packet and routed by S.
- Undriven input: I_valid low with I_ready high has no effect.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- When defined:
  - Adds output port Y_count, 4x16 bits, packed as [63:0] with channel n at [16n+15:16n].
  - Each counter increments by 1 on each beat drained on that channel.
  - Counters wrap from 16'hFFFF to 0 and are cleared by rst.
- When undefined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Reset, then S=2'b10, E=1, single beat I_data=8'hA5 with I_last=1, Y_ready=4'hF -> next cycle Y_valid=4'b0100, Y_data=8'hA5, Y_last=1; the following cycle Y_valid=0.
- 3-beat packet 8'h11, 8'h22, 8'h33 with S=2'b01 on beat 1 and S changed to 2'b11 on beats 2-3 -> all three beats arrive on Y_valid=4'b0010, back-to-back with no bubbles, and the state returns to IDLE.
- Channel 0 stalled (Y_ready=4'b0000) with beat 8'h5C held -> I_ready=0, and Y_data=8'h5C is held steady for 5 cycles. Y_ready[0]=1 then drains it, and I_ready rises in that same cycle.
- E=0 mid-packet, after beat 1 on channel 3 -> I_ready=0 and sel_q is retained. E=1 then sends beats 2-3 to channel 3 even with S=2'b00.
- rst asserted while the entry is full in BUSY -> next cycle Y_valid=0 and Y_data=0. A following beat with S=2'b00 routes to channel 0.
- With DEMUX_COUNT_EN: 4 beats drained on channel 2 -> Y_count[47:32]=4. With the counter preloaded near wrap, 16'hFFFF followed by one more beat -> 0.
